// File: rtl/stacker_pkg.sv
// Shared definitions for the stacker game and its display stage.
// Contents: FSM state enum, frame geometry constants and small helpers
// for building and analysing one 8-cell row.
package stacker_pkg;

    localparam int unsigned ROWS  = 8;
    localparam int unsigned COLS  = 8;
    localparam int unsigned MAP_W = 64;

    typedef enum logic [2:0] {
        StIdle,
        StMove,
        StCheck,
        StWin,
        StLose
    } state_e;

    // Bar of `width` lit cells whose lowest cell sits at column `pos`.
    function automatic logic [COLS-1:0] bar_mask(input logic [3:0] width, input logic [2:0] pos);
        logic [COLS:0] ones;
        ones = (9'd1 << width) - 9'd1;
        return ones[COLS-1:0] << pos;
    endfunction

    function automatic logic [3:0] popcount8(input logic [COLS-1:0] row);
        logic [3:0] cnt;
        cnt = '0;
        for (int i = 0; i < int'(COLS); i++) begin
            cnt = cnt + {3'b000, row[i]};
        end
        return cnt;
    endfunction

    function automatic logic [2:0] lowest_set(input logic [COLS-1:0] row);
        logic [2:0] idx;
        idx = '0;
        for (int i = int'(COLS) - 1; i >= 0; i--) begin
            if (row[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/stacker_game_move_tick.sv
// move_tick: period counter producing a one-cycle tick every `period` cycles.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - synchronous active-low reset (counter to 0)
//   period - cycles per tick (>= 2)
//   clear  - restart counting from 0 on the next edge, suppresses tick
//   tick   - high for the last cycle of each period
module move_tick (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] period,
    input  logic        clear,
    output logic        tick
);

    logic [31:0] cnt_q, cnt_d;

    assign tick = !clear && (cnt_q == period - 32'd1);

    always_comb begin
        cnt_d = cnt_q + 32'd1;
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/stacker_game.sv
// stacker_game: 8x8 stacking game. A bar slides left/right in the current row;
// btn locks it, keeping only the cells supported by the row below.
// Ports:
//   clk, rst_n - clock and synchronous active-low reset
//   start      - pulse, begins a new game from any state
//   btn        - pulse, stops the moving bar
//   map        - registered 64-bit frame, row r in bits [8r+7:8r]
//   level      - current row index
//   win, lose  - game outcome flags
// Build option: define STACKER_SPEEDUP_EN to halve the move period every two rows
// (floor of 2 cycles).
module stacker_game
    import stacker_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 12500000,
    parameter int unsigned START_WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             btn,
    output logic [MAP_W-1:0] map,
    output logic [2:0]       level,
    output logic             win,
    output logic             lose
);

    localparam logic [3:0] StartW = 4'(START_WIDTH);

    state_e           state_q, state_d;
    logic [MAP_W-1:0] rows_q, rows_d;   // locked rows only
    logic [MAP_W-1:0] map_q, map_d;
    logic [2:0]       level_q, level_d;
    logic [3:0]       width_q, width_d;
    logic [2:0]       pos_q, pos_d;
    logic             up_q, up_d;       // 1 = moving towards higher columns
    logic             win_q, win_d;
    logic             lose_q, lose_d;

    logic [31:0]     period;
    logic            tick;
    logic            tick_clear;
    logic [COLS-1:0] bar;
    logic [COLS-1:0] kept;
    logic [3:0]      max_pos;

`ifdef STACKER_SPEEDUP_EN
    logic [31:0] shifted;
    assign shifted = 32'(TICK_DIV) >> level_q[2:1];
    assign period  = (shifted < 32'd2) ? 32'd2 : shifted;
`else
    assign period = 32'(TICK_DIV);
`endif

    // Held at 0 outside MOVE so every entry to MOVE starts a full period.
    assign tick_clear = start || btn || (state_q != StMove);

    move_tick u_move_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .period (period),
        .clear  (tick_clear),
        .tick   (tick)
    );

    assign bar     = bar_mask(width_q, pos_q);
    assign kept    = (level_q == 3'd0) ? bar
                   : (bar & rows_q[{level_q - 3'd1, 3'b000} +: COLS]);
    assign max_pos = 4'(COLS) - width_q;

    always_comb begin
        state_d = state_q;
        rows_d  = rows_q;
        level_d = level_q;
        width_d = width_q;
        pos_d   = pos_q;
        up_d    = up_q;

        if (start) begin
            state_d = StMove;
            rows_d  = '0;
            level_d = '0;
            width_d = StartW;
            pos_d   = '0;
            up_d    = 1'b1;
        end else begin
            unique case (state_q)
                StMove: begin
                    if (btn) begin
                        state_d = StCheck;
                    end else if (tick) begin
                        // At an edge, reverse and step the other way on the same tick.
                        if (up_q) begin
                            if ({1'b0, pos_q} < max_pos) begin
                                pos_d = pos_q + 3'd1;
                            end else begin
                                up_d = 1'b0;
                                if (pos_q != 3'd0) pos_d = pos_q - 3'd1;
                            end
                        end else begin
                            if (pos_q != 3'd0) begin
                                pos_d = pos_q - 3'd1;
                            end else begin
                                up_d = 1'b1;
                                if (max_pos != 4'd0) pos_d = pos_q + 3'd1;
                            end
                        end
                    end
                end
                StCheck: begin
                    if (kept == '0) begin
                        rows_d[{level_q, 3'b000} +: COLS] = '0;
                        state_d = StLose;
                    end else begin
                        rows_d[{level_q, 3'b000} +: COLS] = kept;
                        width_d = popcount8(kept);
                        pos_d   = lowest_set(kept);
                        if (level_q == 3'(ROWS - 1)) begin
                            state_d = StWin;
                        end else begin
                            level_d = level_q + 3'd1;
                            state_d = StMove;
                        end
                    end
                end
                default: ;
            endcase
        end

        // Outputs are computed from next-state values so they change on the same edge.
        unique case (state_d)
            StMove, StCheck:
                map_d = rows_d | (MAP_W'(bar_mask(width_d, pos_d)) << {level_d, 3'b000});
            StIdle:  map_d = '0;
            default: map_d = rows_d;
        endcase
        win_d  = (state_d == StWin);
        lose_d = (state_d == StLose);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            rows_q  <= '0;
            map_q   <= '0;
            level_q <= '0;
            width_q <= StartW;
            pos_q   <= '0;
            up_q    <= 1'b1;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rows_q  <= rows_d;
            map_q   <= map_d;
            level_q <= level_d;
            width_q <= width_d;
            pos_q   <= pos_d;
            up_q    <= up_d;
            win_q   <= win_d;
            lose_q  <= lose_d;
        end
    end

    assign map   = map_q;
    assign level = level_q;
    assign win   = win_q;
    assign lose  = lose_q;

endmodule

// File: tb/tb_stacker_game.sv
// Self-checking bench for stacker_game (TICK_DIV=4, START_WIDTH=3): directed
// scenarios plus random play, compared every cycle with a behavioural game model.
module tb_stacker_game;

    localparam int TickDiv = 4;
    localparam int StartW  = 3;

    localparam int MIdle  = 0;
    localparam int MMove  = 1;
    localparam int MCheck = 2;
    localparam int MWin   = 3;
    localparam int MLose  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        btn;
    logic [63:0] map;
    logic [2:0]  level;
    logic        win;
    logic        lose;

    int n_checks = 0;
    int n_errors = 0;

    // Game model.
    int m_state;
    int m_rows[8];
    int m_level, m_width, m_pos, m_up, m_elapsed;

    always #5 clk = ~clk;

    stacker_game #(
        .TICK_DIV    (TickDiv),
        .START_WIDTH (StartW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .btn   (btn),
        .map   (map),
        .level (level),
        .win   (win),
        .lose  (lose)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int period_of(input int lvl);
        int p;
        p = TickDiv;
`ifdef STACKER_SPEEDUP_EN
        p = TickDiv >> (lvl / 2);
        if (p < 2) p = 2;
`endif
        return p;
    endfunction

    function automatic int bar_of(input int w, input int p);
        return ((1 << w) - 1) << p;
    endfunction

    function automatic logic [63:0] model_map();
        logic [63:0] m;
        m = '0;
        if (m_state == MIdle) return m;
        for (int r = 0; r < 8; r++) m = m | (64'(m_rows[r]) << (8 * r));
        if (m_state == MMove || m_state == MCheck)
            m = m | (64'(bar_of(m_width, m_pos)) << (8 * m_level));
        return m;
    endfunction

    task automatic model_reset();
        m_state = MIdle;
        for (int r = 0; r < 8; r++) m_rows[r] = 0;
        m_level = 0; m_width = StartW; m_pos = 0; m_up = 1; m_elapsed = 0;
    endtask

    task automatic model_clock(input bit st, input bit bt, input bit rs);
        int kept, np;
        if (!rs) begin
            model_reset();
        end else if (st) begin
            model_reset();
            m_state = MMove;
        end else if (m_state == MMove) begin
            if (bt) begin
                m_state = MCheck;
            end else begin
                m_elapsed++;
                if (m_elapsed == period_of(m_level)) begin
                    m_elapsed = 0;
                    np = m_pos + (m_up ? 1 : -1);
                    if (np > 8 - m_width || np < 0) begin
                        m_up = !m_up;
                        np = m_pos + (m_up ? 1 : -1);
                        if (np > 8 - m_width || np < 0) np = m_pos;
                    end
                    m_pos = np;
                end
            end
        end else if (m_state == MCheck) begin
            kept = bar_of(m_width, m_pos);
            if (m_level > 0) kept = kept & m_rows[m_level - 1];
            if (kept == 0) begin
                m_rows[m_level] = 0;
                m_state = MLose;
            end else begin
                m_rows[m_level] = kept;
                m_width = $countones(kept);
                for (int i = 7; i >= 0; i--) if (((kept >> i) & 1) == 1) m_pos = i;
                if (m_level == 7) begin
                    m_state = MWin;
                end else begin
                    m_level++;
                    m_state = MMove;
                    m_elapsed = 0;
                end
            end
        end
    endtask

    // One clock: apply inputs, advance model, check all outputs.
    task automatic drive(input bit st, input bit bt);
        start = st;
        btn   = bt;
        @(posedge clk);
        model_clock(st, bt, rst_n);
        #1;
        start = 1'b0;
        btn   = 1'b0;
        check("map", map, model_map());
        check("level", 64'(level), 64'(m_level));
        check("win", 64'(win), 64'(m_state == MWin));
        check("lose", 64'(lose), 64'(m_state == MLose));
    endtask

    task automatic wait_pos(input int target, input string tag);
        int budget;
        budget = 200;
        while (m_pos != target && budget > 0) begin
            drive(0, 0);
            budget--;
        end
        check({tag, "_reached"}, 64'(m_pos == target), 64'd1);
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        start = 1'b0;
        btn   = 1'b0;
        drive(1, 1);
        drive(0, 0);
        check("reset_map", map, 64'h0);
        check("reset_state", {61'd0, level}, 64'd0);
        rst_n = 1'b1;

        // First move after a full period, then bounce at pos 5.
        drive(1, 0);
        check("start_map", map, 64'h07);
        repeat (4) drive(0, 0);
        check("first_move", map, 64'h0E);
        repeat (16) drive(0, 0);
        check("bounce_top", map, 64'hE0);
        repeat (4) drive(0, 0);
        check("bounce_back", map, 64'h70);

        // Lock row 0 at pos 0.
        drive(1, 0);
        drive(0, 1);
        drive(0, 0);
        check("row0_lock", map, 64'h0707);
        check("row0_level", 64'(level), 64'd1);

        // Row 1 stopped at pos 1 keeps two cells.
        wait_pos(1, "row1_pos1");
        drive(0, 1);
        drive(0, 0);
        check("partial_keep", map, 64'h060607);

        // Row 1 stopped at pos 5 misses entirely.
        drive(1, 0);
        drive(0, 1);
        drive(0, 0);
        wait_pos(5, "row1_pos5");
        drive(0, 1);
        drive(0, 0);
        check("lose_flag", 64'(lose), 64'd1);
        check("lose_map", map, 64'h07);
        drive(0, 1);
        check("lose_frozen", map, 64'h07);
        drive(1, 0);
        check("restart_map", map, 64'h07);
        check("restart_lose", 64'(lose), 64'd0);

        // Perfectly aligned game.
        for (int r = 0; r < 8; r++) begin
            drive(0, 1);
            drive(0, 0);
        end
        check("win_flag", 64'(win), 64'd1);
        check("win_map", map, 64'h0707070707070707);
        drive(0, 1);
        check("win_frozen", map, 64'h0707070707070707);

        // Reach level 4, measure one move period, then reset mid-game.
        drive(1, 0);
        for (int r = 0; r < 4; r++) begin
            drive(0, 1);
            drive(0, 0);
        end
        check("lvl4", 64'(level), 64'd4);
        repeat (period_of(4) - 1) drive(0, 0);
        check("lvl4_before_move", 64'(map[39:32]), 64'h07);
        drive(0, 0);
        check("lvl4_period", 64'(map[39:32]), 64'h0E);
        rst_n = 1'b0;
        drive(0, 1);
        rst_n = 1'b1;
        check("midgame_reset_map", map, 64'h0);
        check("midgame_reset_level", 64'(level), 64'd0);

        // Random play.
        for (int i = 0; i < 4000; i++) begin
            bit st, bt;
            rst_n = ($urandom_range(0, 799) != 0);
            if (m_state == MMove || m_state == MCheck)
                st = ($urandom_range(0, 299) == 0);
            else
                st = ($urandom_range(0, 7) == 0);
            bt = ($urandom_range(0, 5) == 0);
            drive(st, bt);
        end
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
